// File: rtl/packet_add_sched.sv
// Round-robin scheduler that shares one packet_add datapath among NS AXI-Stream sources.
// Grants one source per packet, presents {k,len} for a CONFIG cycle, then streams and truncates at len beats.
module packet_add_sched #(
   parameter int DW = 8,
   parameter int NS = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NS*DW-1:0] s_tdata,
   input  logic [NS-1:0]    s_tvalid,
   input  logic [NS-1:0]    s_tlast,
   output logic [NS-1:0]    s_tready,
   input  logic [NS*DW-1:0] cfg_k,
   input  logic [DW-1:0]    cfg_len,
   output logic [DW-1:0]    m_tdata,
   output logic             m_tvalid,
   output logic             m_tlast,
   input  logic             m_tready,
   output logic [2*DW-1:0]  config_packet,
   output logic [1:0]       grant_id,
   output logic             busy,
   output logic             trunc_err
);
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CONFIG = 2'd1,
      ST_STREAM = 2'd2,
      ST_DRAIN  = 2'd3
   } state_t;

   localparam logic [DW-1:0] ONE_W       = DW'(1);
   localparam logic [1:0]    LAST_ID_RST = 2'(NS - 1);

   state_t          state_r;
   logic [1:0]      grant_r;
   logic [1:0]      last_id_r;
   logic [DW-1:0]   len_r;
   logic [DW-1:0]   beat_cnt_r;
   logic [2*DW-1:0] config_r;
   logic            trunc_r;

   logic            pick_ok_s;
   logic [1:0]      pick_id_s;
   logic [DW-1:0]   pick_k_s;
   logic [NS-1:0]   sel_mask_s;
   logic [DW-1:0]   src_data_s;
   logic            src_valid_s;
   logic            src_last_s;
   logic            at_limit_s;

   function automatic logic [1:0] rr_idx(input logic [1:0] base, input int step);
      return 2'((int'(base) + step) % NS);
   endfunction

   // Round-robin pick: first valid source at or after last_id+1, in modular order
   always_comb begin
      pick_ok_s = 1'b0;
      pick_id_s = 2'd0;
      pick_k_s  = '0;
      for (int d = 1; d <= NS; d++) begin
         for (int j = 0; j < NS; j++) begin
            if (!pick_ok_s && s_tvalid[j] && (rr_idx(last_id_r, d) == 2'(j))) begin
               pick_ok_s = 1'b1;
               pick_id_s = 2'(j);
               pick_k_s  = cfg_k[j*DW +: DW];
            end else begin
               pick_ok_s = pick_ok_s;
            end
         end
      end
   end

   // Select the granted source's stream signals
   always_comb begin
      sel_mask_s  = '0;
      src_data_s  = '0;
      src_valid_s = 1'b0;
      src_last_s  = 1'b0;
      for (int j = 0; j < NS; j++) begin
         if (grant_r == 2'(j)) begin
            sel_mask_s[j] = 1'b1;
            src_data_s    = s_tdata[j*DW +: DW];
            src_valid_s   = s_tvalid[j];
            src_last_s    = s_tlast[j];
         end else begin
            sel_mask_s[j] = 1'b0;
         end
      end
   end

   // The beat about to be accepted is number len (len = 0 never limits)
   assign at_limit_s = (len_r != '0) && (beat_cnt_r == (len_r - ONE_W));

   // Zero-latency stream mux; everything is forced quiet outside STREAM/DRAIN
   always_comb begin
      m_tdata  = '0;
      m_tvalid = 1'b0;
      m_tlast  = 1'b0;
      s_tready = '0;
      case (state_r)
         ST_STREAM: begin
            m_tdata  = src_data_s;
            m_tvalid = src_valid_s;
            m_tlast  = src_last_s | at_limit_s;
            s_tready = sel_mask_s & {NS{m_tready}};
         end
         ST_DRAIN: begin
            s_tready = sel_mask_s;
         end
         default: begin
            m_tdata  = '0;
            m_tvalid = 1'b0;
            m_tlast  = 1'b0;
            s_tready = '0;
         end
      endcase
   end

   // Packet-level FSM with registered grant, config word and truncation pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         grant_r    <= 2'd0;
         last_id_r  <= LAST_ID_RST;
         len_r      <= '0;
         beat_cnt_r <= '0;
         config_r   <= '0;
         trunc_r    <= 1'b0;
      end else begin
         trunc_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (pick_ok_s) begin
                  grant_r    <= pick_id_s;
                  config_r   <= {pick_k_s, cfg_len};
                  len_r      <= cfg_len;
                  beat_cnt_r <= '0;
                  state_r    <= ST_CONFIG;
               end
            end
            ST_CONFIG: begin
               state_r <= ST_STREAM;
            end
            ST_STREAM: begin
               if (src_valid_s && m_tready) begin
                  if (src_last_s) begin
                     last_id_r  <= grant_r;
                     beat_cnt_r <= '0;
                     state_r    <= ST_IDLE;
                  end else if (at_limit_s) begin
                     trunc_r    <= 1'b1;
                     beat_cnt_r <= '0;
                     state_r    <= ST_DRAIN;
                  end else begin
                     beat_cnt_r <= beat_cnt_r + ONE_W;
                  end
               end
            end
            ST_DRAIN: begin
               if (src_valid_s && src_last_s) begin
                  last_id_r <= grant_r;
                  state_r   <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign config_packet = config_r;
   assign grant_id      = grant_r;
   assign trunc_err     = trunc_r;
   assign busy          = (state_r != ST_IDLE);

endmodule

// File: tb/tb_packet_add_sched.sv
// Bench for packet_add_sched: randomized sources and backpressure against a packet-level scoreboard
// plus a per-cycle scheduler model derived from the round-robin / truncation rules.
module tb_packet_add_sched;
   localparam int DW = 8;
   localparam int NS = 2;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NS*DW-1:0] s_tdata;
   logic [NS-1:0]    s_tvalid;
   logic [NS-1:0]    s_tlast;
   logic [NS-1:0]    s_tready;
   logic [NS*DW-1:0] cfg_k;
   logic [DW-1:0]    cfg_len;
   logic [DW-1:0]    m_tdata;
   logic             m_tvalid;
   logic             m_tlast;
   logic             m_tready;
   logic [2*DW-1:0]  config_packet;
   logic [1:0]       grant_id;
   logic             busy;
   logic             trunc_err;

   packet_add_sched #(.DW(DW), .NS(NS)) dut (
      .clk(clk), .rst(rst),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .cfg_k(cfg_k), .cfg_len(cfg_len),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
      .config_packet(config_packet), .grant_id(grant_id), .busy(busy), .trunc_err(trunc_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   beat_t drv_q [NS][$];
   beat_t sb_q  [NS][$];
   int    gap_pct  = 0;
   int    rdy_mode = 0;
   int    cyc      = 0;
   logic [NS-1:0] fire = '0;

   int fwd_cnt   = 0;
   int trunc_cnt = 0;
   int exp_trunc = 0;
   int grant_log [$];
   logic [2*DW-1:0] cfg_log [$];

   // scheduler model: ph 0=idle 1=config 2=stream 3=drain
   int              ph = 0;
   int              g = 0;
   int              last = NS - 1;
   int              cnt = 0;
   int              lim = 0;
   logic [2*DW-1:0] cfgp = '0;
   bit              trunc_pend = 1'b0;
   bit              stream_m, drain_m, lim_hit_m, e_valid_m;
   logic [NS-1:0]   e_ready_m;
   beat_t           exp_b;
   int              w;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [NS-1:0] v, input int lst);
      for (int d = 1; d <= NS; d++) begin
         if (v[(lst + d) % NS]) return (lst + d) % NS;
      end
      return -1;
   endfunction

   // Queue one source packet; the scoreboard keeps only what must reach the datapath
   task automatic add_pkt(input int src, input int n);
      int    lv;
      beat_t x;
      lv = int'(cfg_len);
      for (int b = 0; b < n; b++) begin
         x.d = DW'($urandom);
         x.l = (b == n - 1);
         drv_q[src].push_back(x);
         if (lv == 0 || b < lv) begin
            x.l = (b == n - 1) || (lv != 0 && b == lv - 1);
            sb_q[src].push_back(x);
         end
      end
      if (lv != 0 && n > lv) exp_trunc++;
   endtask

   task automatic scen_start();
      fwd_cnt   = 0;
      trunc_cnt = 0;
      exp_trunc = 0;
      grant_log.delete();
      cfg_log.delete();
   endtask

   task automatic rst_checks();
      chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_m_tlast", 32'(m_tlast), 32'd0);
      chk("rst_m_tdata", 32'(m_tdata), 32'd0);
      chk("rst_s_tready", 32'(s_tready), 32'd0);
      chk("rst_config_packet", 32'(config_packet), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_trunc_err", 32'(trunc_err), 32'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      rst_checks();
      for (int i = 0; i < NS; i++) begin
         drv_q[i].delete();
         sb_q[i].delete();
      end
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
   endtask

   function automatic bit all_idle();
      bit r;
      r = (ph == 0) && (s_tvalid == '0);
      for (int i = 0; i < NS; i++) begin
         if (drv_q[i].size() != 0 || sb_q[i].size() != 0) r = 1'b0;
      end
      return r;
   endfunction

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while (!all_idle() && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk({name, "_complete"}, 32'(all_idle()), 32'd1);
      repeat (2) @(posedge clk);
   endtask

   // Source and sink drivers: inputs change 1 time unit after the rising edge
   initial begin : drivers
      s_tvalid = '0;
      s_tlast  = '0;
      s_tdata  = '0;
      m_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         for (int i = 0; i < NS; i++) begin
            if (rst) begin
               s_tvalid[i]         = 1'b0;
               s_tlast[i]          = 1'b0;
               s_tdata[i*DW +: DW] = '0;
            end else begin
               if (fire[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
               if (s_tvalid[i] && !fire[i]) begin
                  s_tvalid[i] = 1'b1;
               end else if (drv_q[i].size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                  s_tvalid[i]         = 1'b1;
                  s_tdata[i*DW +: DW] = drv_q[i][0].d;
                  s_tlast[i]          = drv_q[i][0].l;
               end else begin
                  s_tvalid[i]         = 1'b0;
                  s_tlast[i]          = 1'b0;
                  s_tdata[i*DW +: DW] = '0;
               end
            end
         end
         case (rdy_mode)
            1:       m_tready = 1'($urandom_range(0, 1));
            2:       m_tready = ((cyc / 2) % 2) == 0;
            default: m_tready = 1'b1;
         endcase
      end
   end

   // Compare process: checks every output each cycle, then advances the model over the edge
   initial begin : compare
      forever begin
         @(negedge clk);
         if (rst) begin
            ph = 0; g = 0; last = NS - 1; cnt = 0; lim = 0; cfgp = '0; trunc_pend = 1'b0; fire = '0;
         end else begin
            stream_m  = (ph == 2);
            drain_m   = (ph == 3);
            lim_hit_m = (lim != 0) && (cnt == lim - 1);
            e_valid_m = stream_m && s_tvalid[g];
            e_ready_m = '0;
            if (stream_m) e_ready_m[g] = m_tready;
            else if (drain_m) e_ready_m[g] = 1'b1;
            chk("busy", 32'(busy), 32'(ph != 0));
            chk("grant_id", 32'(grant_id), 32'(g));
            chk("config_packet", 32'(config_packet), 32'(cfgp));
            chk("trunc_err", 32'(trunc_err), 32'(trunc_pend));
            chk("s_tready", 32'(s_tready), 32'(e_ready_m));
            chk("m_tvalid", 32'(m_tvalid), 32'(e_valid_m));
            chk("m_tdata", 32'(m_tdata), stream_m ? 32'(s_tdata[g*DW +: DW]) : 32'd0);
            chk("m_tlast", 32'(m_tlast), 32'(stream_m && (s_tlast[g] || lim_hit_m)));
            if (e_valid_m && m_tready) begin
               if (sb_q[g].size() == 0) begin
                  chk("sb_beat_expected", 32'd0, 32'd1);
               end else begin
                  exp_b = sb_q[g].pop_front();
                  chk("sb_data", 32'(m_tdata), 32'(exp_b.d));
                  chk("sb_last", 32'(m_tlast), 32'(exp_b.l));
               end
               fwd_cnt++;
            end
            if (trunc_err) trunc_cnt++;
            if (ph == 1) begin
               grant_log.push_back(int'(grant_id));
               cfg_log.push_back(config_packet);
            end
            fire = s_tvalid & s_tready;
            trunc_pend = 1'b0;
            case (ph)
               0: begin
                  w = rr_pick(s_tvalid, last);
                  if (w >= 0) begin
                     g    = w;
                     cfgp = {cfg_k[w*DW +: DW], cfg_len};
                     lim  = int'(cfg_len);
                     ph   = 1;
                  end
               end
               1: begin
                  ph  = 2;
                  cnt = 0;
               end
               2: begin
                  if (s_tvalid[g] && m_tready) begin
                     if (s_tlast[g]) begin
                        last = g;
                        ph   = 0;
                     end else if (lim_hit_m) begin
                        trunc_pend = 1'b1;
                        ph         = 3;
                     end else begin
                        cnt++;
                     end
                  end
               end
               3: begin
                  if (s_tvalid[g] && s_tlast[g]) begin
                     last = g;
                     ph   = 0;
                  end
               end
               default: ph = 0;
            endcase
         end
      end
   end

   initial begin : main
      int n;
      cfg_k   = '0;
      cfg_len = '0;
      @(posedge clk);
      #2;
      rst_checks();
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;

      // single 64-beat packet, no truncation at exactly len beats
      cfg_k = {8'h22, 8'h02};
      cfg_len = 8'd64;
      scen_start();
      add_pkt(0, 64);
      wait_done("s1", 400);
      chk("s1_config", 32'(cfg_log[0]), 32'h0240);
      chk("s1_beats", 32'(fwd_cnt), 32'd64);
      chk("s1_trunc", 32'(trunc_cnt), 32'd0);

      // both sources valid from reset, alternate grants
      do_reset();
      cfg_k = {8'h22, 8'h11};
      cfg_len = 8'd16;
      scen_start();
      add_pkt(0, 4); add_pkt(1, 4); add_pkt(0, 4); add_pkt(1, 4);
      wait_done("s2", 200);
      chk("s2_grant0", 32'(grant_log[0]), 32'd0);
      chk("s2_grant1", 32'(grant_log[1]), 32'd1);
      chk("s2_grant2", 32'(grant_log[2]), 32'd0);
      chk("s2_grant3", 32'(grant_log[3]), 32'd1);
      chk("s2_config1", 32'(cfg_log[1]), 32'h2210);

      // truncation of a 7-beat packet at len 4, then a normal packet
      cfg_len = 8'd4;
      scen_start();
      add_pkt(0, 7); add_pkt(0, 3);
      wait_done("s3", 200);
      chk("s3_trunc", 32'(trunc_cnt), 32'd1);
      chk("s3_beats", 32'(fwd_cnt), 32'd7);

      // backpressure toggling every 2 cycles; len equals packet length
      cfg_len = 8'd10;
      rdy_mode = 2;
      scen_start();
      add_pkt(1, 10);
      wait_done("s4", 200);
      chk("s4_beats", 32'(fwd_cnt), 32'd10);
      chk("s4_trunc", 32'(trunc_cnt), 32'd0);
      rdy_mode = 0;

      // reset at beat 3 of 8, restart with both sources pending
      cfg_len = 8'd0;
      scen_start();
      add_pkt(0, 8);
      n = 0;
      while (fwd_cnt < 2 && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("s5_reached_beat3", 32'(fwd_cnt), 32'd2);
      do_reset();
      scen_start();
      add_pkt(1, 3); add_pkt(0, 8);
      wait_done("s5", 200);
      chk("s5_first_grant", 32'(grant_log[0]), 32'd0);
      chk("s5_second_grant", 32'(grant_log[1]), 32'd1);
      chk("s5_beats", 32'(fwd_cnt), 32'd11);

      // unlimited length, 300 beats (beat counter wraps)
      scen_start();
      add_pkt(0, 300);
      wait_done("s6", 1000);
      chk("s6_beats", 32'(fwd_cnt), 32'd300);
      chk("s6_trunc", 32'(trunc_cnt), 32'd0);

      // randomized traffic, gaps and backpressure
      gap_pct  = 30;
      rdy_mode = 1;
      for (int it = 0; it < 6; it++) begin
         cfg_len = DW'($urandom_range(0, 6));
         cfg_k   = (NS*DW)'($urandom);
         scen_start();
         for (int p = 0; p < 6; p++) add_pkt($urandom_range(0, NS - 1), $urandom_range(1, 12));
         wait_done("rand", 3000);
         chk("rand_trunc", 32'(trunc_cnt), 32'(exp_trunc));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
